// File: rtl/device_regs_master_pkg.sv
// Shared definitions for the command-to-register-bus master.
// Purpose : FSM state encoding, default bus geometry and read-wait helpers.
// Ports   : none (package).
package device_regs_master_pkg;

  // Default geometry of the register bus and its target.
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_RD_LAT   = 1;

  // Wide enough to hold RD_LAT-1 for the largest legal RD_LAT (3).
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Value loaded into the read-wait down-counter when leaving READ.
  // RD_WAIT lasts (load + 1) cycles, i.e. exactly rd_lat cycles.
  function automatic logic [CNT_W-1:0] rd_wait_load(input int rd_lat);
    return CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/device_regs_master.sv
// Command-to-register-bus master: one command in flight, registered bus strobes.
// Latency : accept edge to first rsp_valid cycle = write 2, read 2+RD_LAT, error 1.
// Backpr. : cmd_ready only in IDLE; response held in RESP until rsp_ready.
//
// Ports
//   clk, resetb              clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   address/data_in          register-bus address and write data (registered)
//   write_en/read_en         one-cycle register-bus strobes (registered, never together)
//   read_data                registered read data from the target, RD_LAT cycles after read_en
//   rsp_valid/rsp_ready      response handshake; rsp_write/rsp_rdata/rsp_err payload
//   busy                     high whenever the FSM is not IDLE
//
// RD_LAT is legal in 1..3 only (counter is CNT_W bits wide).
module device_regs_master
  import device_regs_master_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              resetb,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // register bus
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic              read_en,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] read_data,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // status
  output logic              busy
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LOAD    = rd_wait_load(RD_LAT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_data_in;
  logic                r_write_en;
  logic                r_read_en;
  logic                r_rsp_valid;
  logic                r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  // Next-cycle values of the registered outputs.
  logic                w_write_en_nxt;
  logic                w_read_en_nxt;
  logic                w_rsp_valid_nxt;

  logic                w_idle;
  logic                w_accept;
  logic                w_addr_err;
  logic                w_rd_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = cmd_valid && w_idle;
  assign w_addr_err = ({1'b0, cmd_addr} >= NUM_REGS_EXT);
  // Last RD_WAIT cycle: the target's registered data is valid now.
  assign w_rd_last  = (r_state == ST_RD_WAIT) && (r_cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (w_addr_err) begin
            w_state_nxt = ST_RESP;
          end else if (cmd_write) begin
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_WRITE:   w_state_nxt = ST_RESP;
      ST_READ:    w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output logic
  // Strobes and rsp_valid are registered, so they are decoded from the state
  // being entered; WRITE and READ are only ever entered from IDLE and always
  // exit after one cycle, which makes each strobe exactly one cycle wide and
  // keeps the two mutually exclusive.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_write_en_nxt  = (w_state_nxt == ST_WRITE);
    w_read_en_nxt   = (w_state_nxt == ST_READ);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);

    w_cnt_nxt = r_cnt;
    if (r_state == ST_READ) begin
      w_cnt_nxt = CNT_LOAD;
    end else if ((r_state == ST_RD_WAIT) && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and captured command
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt       <= '0;
      r_address   <= '0;
      r_data_in   <= '0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_write_en  <= w_write_en_nxt;
      r_read_en   <= w_read_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;

      // The bus address/data are only updated here, so they stay put through
      // the whole transaction and keep the last command's values while idle.
      if (w_accept) begin
        r_address   <= cmd_addr;
        r_data_in   <= cmd_wdata;
        r_rsp_write <= cmd_write;
        r_rsp_err   <= w_addr_err;
        r_rsp_rdata <= '0;
      end

      if (w_rd_last) begin
        r_rsp_rdata <= read_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign cmd_ready = w_idle;
  assign busy      = !w_idle;
  assign address   = r_address;
  assign data_in   = r_data_in;
  assign write_en  = r_write_en;
  assign read_en   = r_read_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_device_regs_master.sv
// Bench for device_regs_master: table of commands plus reset-abort and
// back-to-back sequences; a small register-file target answers the bus.
module tb_device_regs_master;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int RL = 1;
  localparam int LAT_WR  = 2;
  localparam int LAT_RD  = 2 + RL;
  localparam int LAT_ERR = 1;

  logic          clk = 1'b0;
  logic          resetb;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] address;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] read_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  always #5 clk = ~clk;

  device_regs_master #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LAT(RL)
  ) dut (
    .clk(clk), .resetb(resetb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .address(address), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  exp_t          exp_q[$];
  exp_t          pend;
  vec_t          vecs[11];
  logic [DW-1:0] tregs[NR];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            n_rsp = 0;
  int            last_acc = 0;
  int            last_hs = 0;
  int            wr_pulses, rd_pulses;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor and scoreboard, evaluated on values stable before the edge.
  task automatic observe();
    exp_t e;
    if (write_en || read_en) chk("strobe_exclusive", 32'({write_en, read_en} == 2'b11), 32'(0));
    if (write_en) begin wr_pulses++; st_addr = address; st_data = data_in; end
    if (read_en)  begin rd_pulses++; st_addr = address; end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q[0];
        if (!prev_vld) chk("rsp_latency", cyc - e.acc, e.lat);
        chk("rsp_write", 32'(rsp_write), 32'(e.wr));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'(0));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          n_rsp++;
          last_hs = cyc;
        end
      end
    end
    prev_vld = rsp_valid;
    if (cmd_valid && cmd_ready) begin
      e = pend;
      e.acc = cyc;
      exp_q.push_back(e);
      last_acc = cyc;
    end
  endtask

  // One clock: observe, let the edge happen, update the RD_LAT=1 target.
  task automatic step();
    logic [DW-1:0] nxt;
    nxt = read_data;
    if (read_en && (32'(address) < NR)) nxt = tregs[address[1:0]];
    if (write_en && (32'(address) < NR)) tregs[address[1:0]] = data_in;
    observe();
    @(posedge clk);
    @(negedge clk);
    read_data = nxt;
    cyc++;
  endtask

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold, input logic [DW-1:0] er, input logic ee, input int lat);
    int guard;
    int start_rsp;
    exp_q.delete();
    pend.wr = wr; pend.rdata = er; pend.err = ee; pend.lat = lat; pend.acc = 0;
    wr_pulses = 0; rd_pulses = 0; st_addr = '0; st_data = '0;
    start_rsp = n_rsp;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    rsp_ready = (hold == 0);
    guard = 0;
    while (!cmd_ready && guard < 20) begin step(); guard++; end
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    guard = 0;
    while (!rsp_valid && guard < 20) begin step(); guard++; end
    chk("rsp_seen", 32'(rsp_valid), 32'(1));
    for (int i = 0; i < hold; i++) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_count", n_rsp - start_rsp, 1);
    chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
    chk("cmd_ready_back", 32'(cmd_ready), 32'(1));
    chk("busy_back", 32'(busy), 32'(0));
    chk("wr_pulses", wr_pulses, (!ee && wr) ? 1 : 0);
    chk("rd_pulses", rd_pulses, (!ee && !wr) ? 1 : 0);
    if (!ee) chk("strobe_addr", 32'(st_addr), 32'(a));
    if (!ee && wr) chk("strobe_data", 32'(st_data), 32'(d));
    chk("addr_retained", 32'(address), 32'(a));
    chk("data_retained", 32'(data_in), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hs1, acc2;
    tregs[0] = 8'h5A; tregs[1] = 8'h3C; tregs[2] = 8'h00; tregs[3] = 8'h77;
    read_data = '0;
    resetb = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    pend = '{1'b0, 8'h00, 1'b0, 0, 0};

    //             wr    addr   wdata  hold rdata  err   lat
    vecs[0]  = '{1'b1, 4'd2,  8'hA5, 0, 8'h00, 1'b0, LAT_WR};
    vecs[1]  = '{1'b0, 4'd1,  8'h00, 0, 8'h3C, 1'b0, LAT_RD};
    vecs[2]  = '{1'b0, 4'd7,  8'h00, 0, 8'h00, 1'b1, LAT_ERR};
    vecs[3]  = '{1'b0, 4'd2,  8'h5E, 5, 8'hA5, 1'b0, LAT_RD};
    vecs[4]  = '{1'b1, 4'd4,  8'hFF, 2, 8'h00, 1'b1, LAT_ERR};
    vecs[5]  = '{1'b0, 4'd3,  8'h00, 0, 8'h77, 1'b0, LAT_RD};
    vecs[6]  = '{1'b1, 4'd3,  8'hC3, 5, 8'h00, 1'b0, LAT_WR};
    vecs[7]  = '{1'b0, 4'd3,  8'h81, 1, 8'hC3, 1'b0, LAT_RD};
    vecs[8]  = '{1'b0, 4'd15, 8'h00, 0, 8'h00, 1'b1, LAT_ERR};
    vecs[9]  = '{1'b1, 4'd15, 8'h12, 0, 8'h00, 1'b1, LAT_ERR};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 0, 8'h5A, 1'b0, LAT_RD};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_address", 32'(address), 32'(0));
    chk("rst_data_in", 32'(data_in), 32'(0));
    chk("rst_strobes", 32'({write_en, read_en}), 32'(0));
    chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'(0));
    chk("rst_rdata", 32'(rsp_rdata), 32'(0));
    resetb = 1'b1;
    step();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rel_busy", 32'(busy), 32'(0));

    // Table-driven commands
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
              vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      step();
    end

    // Reset during RD_WAIT aborts the read with no response
    exp_q.delete();
    pend = '{1'b0, 8'h5A, 1'b0, LAT_RD, 0};
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_wdata = 8'h00;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_busy_before", 32'(busy), 32'(1));
    resetb = 1'b0;
    #1;
    chk("abort_address", 32'(address), 32'(0));
    chk("abort_data_in", 32'(data_in), 32'(0));
    chk("abort_strobes", 32'({write_en, read_en}), 32'(0));
    chk("abort_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'(0));
    chk("abort_rdata", 32'(rsp_rdata), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    exp_q.delete();
    prev_vld = 1'b0;
    step();
    resetb = 1'b1;
    chk("post_rel_strobes", 32'({write_en, read_en}), 32'(0));
    for (int i = 0; i < 4; i++) begin
      chk("post_rel_no_rsp", 32'(rsp_valid), 32'(0));
      step();
    end
    run_cmd(1'b0, 4'd0, 8'h00, 0, 8'h5A, 1'b0, LAT_RD);

    // Back-to-back write then read with rsp_ready high
    run_cmd(1'b1, 4'd0, 8'h11, 0, 8'h00, 1'b0, LAT_WR);
    hs1 = last_hs;
    run_cmd(1'b0, 4'd0, 8'h00, 0, 8'h11, 1'b0, LAT_RD);
    acc2 = last_acc;
    chk("b2b_accept_gap", acc2 - hs1, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
